// File: rtl/mtr_drv_if.sv
// Command and gate-drive bundle between the balance controller side and
// the H-bridge driver.
interface mtr_drv_if;
    logic               en;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               lft_hi;
    logic               lft_lo;
    logic               rght_hi;
    logic               rght_lo;
    logic               pwm_synch;

    modport master (
        output en, lft_spd, rght_spd,
        input  lft_hi, lft_lo, rght_hi, rght_lo, pwm_synch
    );

    modport slave (
        input  en, lft_spd, rght_spd,
        output lft_hi, lft_lo, rght_hi, rght_lo, pwm_synch
    );
endinterface

// File: rtl/mtr_drv.sv
// Dual-channel complementary PWM generator with dead-time insertion.
// Duty is latched once per 2048-clock period so gate edges never glitch.
module mtr_drv #(
    parameter int DEAD_CLKS = 32
) (
    input  logic      clk,
    input  logic      rst,
    mtr_drv_if.slave  bus
);

    localparam logic [7:0] DEAD_INIT    = 8'(DEAD_CLKS);
    localparam logic [7:0] DEAD_RESTART = 8'(DEAD_CLKS - 1);

    // Saturate to +/-1023 and offset so that zero speed is 50% duty.
    function automatic logic [10:0] sat_duty(input logic signed [11:0] spd);
        logic signed [11:0] c;
        logic signed [12:0] s;
        if (spd > 12'sd1023)
            c = 12'sd1023;
        else if (spd < -12'sd1023)
            c = -12'sd1023;
        else
            c = spd;
        s = 13'sd1024 + {c[11], c};
        return s[10:0];
    endfunction

    logic [10:0] r_cnt;
    logic        r_synch;
    logic [10:0] r_duty   [2];
    logic [10:0] w_cond   [2];
    logic [1:0]  w_raw;
    logic [1:0]  r_raw_q;
    logic [7:0]  r_dead   [2];
    logic [1:0]  r_hi;
    logic [1:0]  r_lo;

    always_comb begin
        w_cond[0] = sat_duty(bus.lft_spd);
        w_cond[1] = sat_duty(bus.rght_spd);
        w_raw     = '0;
        for (int ch = 0; ch < 2; ch++)
            w_raw[ch] = (r_cnt < r_duty[ch]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_synch <= 1'b0;
            r_raw_q <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                r_duty[ch] <= 11'd1024;
                r_dead[ch] <= DEAD_INIT;
            end
        end else begin
            r_cnt   <= r_cnt + 11'd1;
            r_synch <= (r_cnt == 11'd2047);
            r_raw_q <= w_raw;
            for (int ch = 0; ch < 2; ch++) begin
                if (r_cnt == 11'd2047)
                    r_duty[ch] <= w_cond[ch];
                // Any raw edge, or a disable, forces both gates low and
                // (re)starts the dead-time interval.
                if (!bus.en) begin
                    r_dead[ch] <= DEAD_INIT;
                    r_hi[ch]   <= 1'b0;
                    r_lo[ch]   <= 1'b0;
                end else if (w_raw[ch] != r_raw_q[ch]) begin
                    r_dead[ch] <= DEAD_RESTART;
                    r_hi[ch]   <= 1'b0;
                    r_lo[ch]   <= 1'b0;
                end else if (r_dead[ch] != 8'd0) begin
                    r_dead[ch] <= r_dead[ch] - 8'd1;
                    r_hi[ch]   <= 1'b0;
                    r_lo[ch]   <= 1'b0;
                end else begin
                    r_hi[ch]   <= r_raw_q[ch];
                    r_lo[ch]   <= ~r_raw_q[ch];
                end
            end
        end
    end

    assign bus.lft_hi    = r_hi[0];
    assign bus.lft_lo    = r_lo[0];
    assign bus.rght_hi   = r_hi[1];
    assign bus.rght_lo   = r_lo[1];
    assign bus.pwm_synch = r_synch;

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv: measures per-period gate widths, enable and
// reset behaviour, and watches for shoot-through on both channels.
module tb_mtr_drv;

    logic clk = 1'b0;
    logic rst;
    int   n_checks  = 0;
    int   n_errs    = 0;
    int   n_overlap = 0;

    mtr_drv_if bus ();

    mtr_drv #(.DEAD_CLKS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if ((bus.lft_hi && bus.lft_lo) || (bus.rght_hi && bus.rght_lo))
            n_overlap++;

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts one full period starting at the negedge where pwm_synch is
    // high (cnt==0). Optionally changes lft_spd at window index chg_at.
    task automatic measure(input int chg_at, input logic [11:0] chg_val,
                           output int lh, output int ll, output int rh,
                           output int rl, output int sy);
        bit found;
        found = 1'b0;
        lh = 0; ll = 0; rh = 0; rl = 0; sy = 0;
        for (int i = 0; i < 2100 && !found; i++) begin
            @(negedge clk);
            if (bus.pwm_synch) found = 1'b1;
        end
        check_eq("synch_wait", int'(found), 1);
        for (int i = 0; i < 2048; i++) begin
            if (i > 0) @(negedge clk);
            if (i == chg_at) bus.lft_spd = chg_val;
            lh += int'(bus.lft_hi);
            ll += int'(bus.lft_lo);
            rh += int'(bus.rght_hi);
            rl += int'(bus.rght_lo);
            sy += int'(bus.pwm_synch);
        end
    endtask

    function automatic int outs();
        return int'({bus.lft_hi, bus.lft_lo, bus.rght_hi, bus.rght_lo});
    endfunction

    initial begin
        int lh, ll, rh, rl, sy, n;
        bit seen;

        rst = 1'b1;
        bus.en = 1'b0;
        bus.lft_spd = 12'h000;
        bus.rght_spd = 12'h000;
        repeat (5) @(negedge clk);
        check_eq("rst_outs", outs(), 0);
        check_eq("rst_synch", int'(bus.pwm_synch), 0);
        rst = 1'b0;
        bus.en = 1'b1;

        // Zero speed: 50% duty minus dead time on each side
        measure(-1, 12'h000, lh, ll, rh, rl, sy);
        check_eq("t1_lft_hi", lh, 992);
        check_eq("t1_lft_lo", ll, 992);
        check_eq("t1_rght_hi", rh, 992);
        check_eq("t1_rght_lo", rl, 992);
        check_eq("t1_synch", sy, 1);

        bus.lft_spd = 12'h200;
        bus.rght_spd = 12'hE00;
        measure(-1, 12'h000, lh, ll, rh, rl, sy);
        check_eq("t2_lft_hi", lh, 1504);
        check_eq("t2_lft_lo", ll, 480);
        check_eq("t2_rght_hi", rh, 480);
        check_eq("t2_rght_lo", rl, 1504);

        bus.lft_spd = 12'h7FF;
        measure(-1, 12'h000, lh, ll, rh, rl, sy);
        measure(-1, 12'h000, lh, ll, rh, rl, sy);
        check_eq("t3_max_hi", lh, 2015);
        check_eq("t3_max_lo", ll, 0);
        bus.lft_spd = 12'h400;
        measure(-1, 12'h000, lh, ll, rh, rl, sy);
        check_eq("t3_clamp_pos_hi", lh, 2015);
        bus.lft_spd = 12'h800;
        measure(-1, 12'h000, lh, ll, rh, rl, sy);
        measure(-1, 12'h000, lh, ll, rh, rl, sy);
        check_eq("t3_min_hi", lh, 0);
        check_eq("t3_min_lo", ll, 2015);
        bus.lft_spd = 12'hC00;
        measure(-1, 12'h000, lh, ll, rh, rl, sy);
        check_eq("t3_clamp_neg_lo", ll, 2015);

        // Mid-period command change must not disturb the running period
        bus.lft_spd = 12'h000;
        measure(-1, 12'h000, lh, ll, rh, rl, sy);
        measure(500, 12'h100, lh, ll, rh, rl, sy);
        check_eq("t4_cur_hi", lh, 992);
        measure(-1, 12'h000, lh, ll, rh, rl, sy);
        check_eq("t4_next_hi", lh, 1248);

        seen = 1'b0;
        for (int i = 0; i < 2100 && !seen; i++) begin
            @(negedge clk);
            if (bus.lft_hi) seen = 1'b1;
        end
        check_eq("t5_hi_wait", int'(seen), 1);
        bus.en = 1'b0;
        @(negedge clk);
        check_eq("t5_dis_outs", outs(), 0);
        repeat (100) @(negedge clk);
        check_eq("t5_dis_hold", outs(), 0);
        bus.en = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.lft_hi) seen = 1'b1;
            else n++;
        end
        check_eq("t5_dead_len", n, 32);
        check_eq("t5_en_outs", outs(), 4'b1010);

        repeat (500) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_outs", outs(), 0);
        check_eq("t6_rst_synch", int'(bus.pwm_synch), 0);
        rst = 1'b0;
        lh = 0; ll = 0; rh = 0; sy = 0;
        for (int i = 0; i < 2048; i++) begin
            if (i > 0) @(negedge clk);
            lh += int'(bus.lft_hi);
            ll += int'(bus.lft_lo);
            rh += int'(bus.rght_hi);
            sy += int'(bus.pwm_synch);
        end
        check_eq("t6_lft_hi", lh, 992);
        check_eq("t6_lft_lo", ll, 991);
        check_eq("t6_rght_hi", rh, 992);
        check_eq("t6_win_synch", sy, 0);
        @(negedge clk);
        check_eq("t6_synch_at_2048", int'(bus.pwm_synch), 1);

        check_eq("shoot_through", n_overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/mtr_drv.md
Name: mtr_drv

Overview:
- Motor-side consumer of the balance controller's signed 12-bit lft_spd/rght_spd commands.
- Converts each command into a complementary high-side/low-side PWM pair for one H-bridge leg per motor.
- Inserts programmable dead time between complementary outputs.
- Duty updates only at period boundaries, so output edges are glitch-free.

Parameters:
- DEAD_CLKS, 32: clocks both outputs of a channel are held low after any raw PWM transition (legal range 1..255).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en  input  1  drive enable; 0 forces all gate outputs low
- lft_spd  input  12  signed left motor command from balance_cntrl
- rght_spd  input  12  signed right motor command from balance_cntrl
- lft_hi  output  1  left high-side gate drive
- lft_lo  output  1  left low-side gate drive
- rght_hi  output  1  right high-side gate drive
- rght_lo  output  1  right low-side gate drive
- pwm_synch  output  1  one-cycle pulse, high when cnt==0

Behaviour:
- Reset: one clock, reset is synchronous and active-high. On a clock edge with rst=1:
  - cnt=0; both duty regs=11'd1024.
  - raw_q=0; dead_cnt=DEAD_CLKS per channel.
  - All gate outputs 0; pwm_synch=0.
- Period counter: 11-bit cnt, increments every clock, wraps 2047->0, so the period is 2048 clocks. pwm_synch is registered and high in the cycle where cnt==0.
- Command conditioning, per channel, combinational:
  - Clamp the signed speed to [-1023,+1023]; 12'h800..12'hC00 becomes -1023, 12'h400..12'h7FF becomes +1023.
  - duty = 1024 + clamped value, giving range 1..2047.
- Duty sampling: the duty register loads the conditioned value only on the clock where cnt==2047. The new duty therefore takes effect from cnt==0. Input changes at any other time do not affect the current period.
- Raw PWM, combinational: raw = (cnt < duty_reg). For duty 1024 this is high for cnt 0..1023 and low for 1024..2047.
- Dead-time engine, per channel, registered:
  - raw_q <= raw every clock.
  - If en=0: dead_cnt <= DEAD_CLKS; hi, lo <= 0.
  - Else if raw != raw_q: an edge occurred. dead_cnt <= DEAD_CLKS-1; hi, lo <= 0.
  - Else if dead_cnt != 0: dead_cnt decrements; hi, lo <= 0.
  - Else: hi <= raw_q; lo <= ~raw_q.
- Resulting timing: for a raw edge at cycle t, both outputs are low for t+1..t+DEAD_CLKS, and the matching output asserts at t+DEAD_CLKS+1.
  - A raw phase shorter than DEAD_CLKS+1 clocks never asserts its output.
  - A new edge during dead time restarts dead time.
- Invariant: hi and lo of a channel are never 1 in the same cycle, under any input sequence including reset and en toggling.
- Enable:
  - en falling: outputs go 0 on the next edge.
  - en rising: at least DEAD_CLKS cycles with outputs low before either output asserts. cnt and duty sampling continue regardless of en.
- Mid-operation rst: all state returns to reset values on that edge. After release, the first raw edge (raw=1, raw_q=0 at cnt=0) starts a dead-time interval.
- too_fast is not consumed by this block. Shutdown is via en.

Test Plan:
1. rst=1 for 5 clks, then en=1, lft_spd=0 -> all outputs 0 during reset. Steady state: lft_hi high 992 clks, lft_lo high 992 clks per 2048-clk period, with 32-clk gaps. pwm_synch pulses every 2048 clks.
2. lft_spd=12'h200 (+512), rght_spd=12'hE00 (-512) -> lft_hi width 1504, lft_lo width 480; rght_hi width 480, rght_lo width 1504; new widths begin at the first cnt==0 after the change.
3. lft_spd=12'h7FF -> duty 2047: lft_hi width 2015, lft_lo never asserts. lft_spd=12'h800 -> duty 1: lft_hi never asserts, lft_lo width 2015.
4. Change lft_spd from 0 to 12'h100 at cnt==500 -> current period keeps its 992-clk hi. The next period has hi width 1248.
5. Deassert en while lft_hi=1 -> all outputs 0 next cycle. Reassert en during a steady raw phase -> outputs stay 0 exactly 32 clks, then the raw-matching output rises.
6. Assert rst for 1 clk mid-period -> cnt=0, duties reset to 1024, outputs 0. Throughout all tests, a checker flags any cycle with hi&lo=1 on either channel.
